// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default operand
// width and the controller state encoding.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and keep or restore.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit,
  output logic             borrow
);

  // The partial remainder entering an iteration is always below the divisor,
  // so its top bit is zero and only WIDTH bits are carried between steps.
  // The trial difference itself is formed WIDTH+1 bits wide.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] sub_b;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] carry;

  assign shifted  = {r, q_msb};
  assign sub_b    = ~{1'b0, divisor};
  assign carry[0] = 1'b1;

  // Ripple add of the inverted divisor with carry-in 1 (two's complement subtract).
  for (genvar i = 0; i <= WIDTH; i++) begin : g_ripple
    assign diff[i] = shifted[i] ^ sub_b[i] ^ carry[i];
    if (i < WIDTH) begin : g_carry
      assign carry[i+1] = (shifted[i] & sub_b[i]) | (shifted[i] & carry[i]) |
                          (sub_b[i] & carry[i]);
    end
  end

  // A set sign bit means the divisor did not fit: restore the shifted value.
  assign borrow = diff[WIDTH];
  assign q_bit  = ~diff[WIDTH];
  assign r_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider. Operands are captured on an
// accepted start, one quotient bit is resolved per clock, and results are
// registered with a one-cycle done pulse.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic             zero_flag;
  logic             accept;

  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] quo_acc;
  logic [WIDTH-1:0] div_reg;

  logic [WIDTH-1:0] step_r;
  logic             step_q;
  logic             unused_borrow;

  // A request is taken when idle or while finishing (back-to-back); never in RUN.
  assign accept = start && ((state == ST_IDLE) || (state == ST_FIN));
  assign busy   = (state != ST_IDLE);

  // The quotient bit already encodes the borrow, so the borrow output is not needed here.
  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r      (rem_acc),
    .q_msb  (quo_acc[WIDTH-1]),
    .divisor(div_reg),
    .r_next (step_r),
    .q_bit  (step_q),
    .borrow (unused_borrow)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a zero divisor skips the iterations and goes straight to FIN.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = (divisor == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (count == LAST_ITER) begin
          next_state = ST_FIN;
        end
      end
      ST_FIN: begin
        if (start) begin
          next_state = (divisor == '0) ? ST_FIN : ST_RUN;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Control and result registers: iteration count, done pulse and held outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count       <= '0;
      zero_flag   <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == ST_FIN);
      // Publishing the finished result takes priority over clearing the flag
      // for a request accepted in the same FIN cycle.
      if (state == ST_FIN) begin
        quotient    <= quo_acc;
        remainder   <= rem_acc;
        div_by_zero <= zero_flag;
      end else if (accept) begin
        div_by_zero <= 1'b0;
      end
      if (accept) begin
        count     <= '0;
        zero_flag <= (divisor == '0);
      end else if (state == ST_RUN) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Working registers: operand capture on accept, one shift-subtract step per RUN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      div_reg <= divisor;
      if (divisor == '0) begin
        quo_acc <= '1;
        rem_acc <= dividend;
      end else begin
        quo_acc <= dividend;
        rem_acc <= '0;
      end
    end else if (state == ST_RUN) begin
      rem_acc <= step_r;
      quo_acc <= {quo_acc[WIDTH-2:0], step_q};
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus a random sweep,
// with expected results queued at issue time and popped at each done.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; operands are scrambled afterwards to show they are not re-sampled.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    tick();
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic wait_done(input int limit, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < limit) begin
      tick();
      cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (quotient !== '0) begin miscompares++; $display("FAIL reset_quotient got %h want 0", quotient); end
    vectors++; if (remainder !== '0) begin miscompares++; $display("FAIL reset_remainder got %h want 0", remainder); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc; bit seen; exp_t e;
    issue(16'd100, 16'd7);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %b want 1", busy); end
    wait_done(40, cyc, seen);
    e = sb.pop_front();
    vectors++; if (!seen || cyc != 17) begin miscompares++; $display("FAIL basic_latency got %0d edges seen=%0b want 17", cyc, seen); end
    vectors++; if ({quotient, remainder, div_by_zero} !== e) begin miscompares++;
      $display("FAIL basic_result got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b", quotient, remainder, div_by_zero, e.q, e.r, e.dbz); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after got %b want 0", busy); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_extremes();
    int cyc; bit seen; exp_t e;
    logic [W-1:0] av [2] = '{16'hFFFF, 16'd3};
    logic [W-1:0] bv [2] = '{16'd1, 16'd10};
    for (int i = 0; i < 2; i++) begin
      issue(av[i], bv[i]);
      wait_done(40, cyc, seen);
      e = sb.pop_front();
      vectors++; if (!seen || cyc != 17) begin miscompares++; $display("FAIL extreme%0d_latency got %0d seen=%0b want 17", i, cyc, seen); end
      vectors++; if ({quotient, remainder, div_by_zero} !== e) begin miscompares++;
        $display("FAIL extreme%0d_result got q=%h r=%h z=%b want q=%h r=%h z=%b", i, quotient, remainder, div_by_zero, e.q, e.r, e.dbz); end
    end
  endtask

  task automatic test_div_zero();
    int cyc; bit seen; exp_t e;
    issue(16'd5, 16'd0);
    wait_done(10, cyc, seen);
    e = sb.pop_front();
    vectors++; if (!seen || cyc != 1) begin miscompares++; $display("FAIL dbz_latency got %0d seen=%0b want 1", cyc, seen); end
    vectors++; if ({quotient, remainder, div_by_zero} !== e) begin miscompares++;
      $display("FAIL dbz_result got q=%h r=%0d z=%b want q=%h r=%0d z=%b", quotient, remainder, div_by_zero, e.q, e.r, e.dbz); end
    issue(16'd20, 16'd4);
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL dbz_clear got %b want 0", div_by_zero); end
    wait_done(40, cyc, seen);
    e = sb.pop_front();
    vectors++; if (!seen || {quotient, remainder, div_by_zero} !== e) begin miscompares++;
      $display("FAIL dbz_next_result got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b", quotient, remainder, div_by_zero, e.q, e.r, e.dbz); end
  endtask

  task automatic test_ignore_in_run();
    int cyc; bit seen; exp_t e;
    issue(16'd1000, 16'd3);
    repeat (4) tick();
    dividend = 16'd9; divisor = 16'd9; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40, cyc, seen);
    e = sb.pop_front();
    vectors++; if (!seen || cyc != 12) begin miscompares++; $display("FAIL ignore_latency got %0d seen=%0b want 12", cyc, seen); end
    vectors++; if ({quotient, remainder, div_by_zero} !== e) begin miscompares++;
      $display("FAIL ignore_result got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b", quotient, remainder, div_by_zero, e.q, e.r, e.dbz); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if ({busy, done, quotient, remainder, div_by_zero} !== {2'b00, e}) begin miscompares++;
        $display("FAIL ignore_hold%0d got busy=%b done=%b q=%0d r=%0d want busy=0 done=0 q=%0d r=%0d", i, busy, done, quotient, remainder, e.q, e.r); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit seen; exp_t e;
    dividend = 16'd50000; divisor = 16'd123; start = 1'b1;
    sb.push_back(model(16'd50000, 16'd123));
    tick();
    dividend = 16'd255; divisor = 16'd16;
    sb.push_back(model(16'd255, 16'd16));
    wait_done(40, cyc, seen);
    start = 1'b0;
    e = sb.pop_front();
    vectors++; if (!seen || cyc != 17) begin miscompares++; $display("FAIL b2b_first_latency got %0d seen=%0b want 17", cyc, seen); end
    vectors++; if ({quotient, remainder, div_by_zero} !== e) begin miscompares++;
      $display("FAIL b2b_first_result got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b", quotient, remainder, div_by_zero, e.q, e.r, e.dbz); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_no_idle got busy=%b want 1", busy); end
    wait_done(40, cyc, seen);
    e = sb.pop_front();
    vectors++; if (!seen || cyc != 17) begin miscompares++; $display("FAIL b2b_second_latency got %0d seen=%0b want 17", cyc, seen); end
    vectors++; if ({quotient, remainder, div_by_zero} !== e) begin miscompares++;
      $display("FAIL b2b_second_result got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b", quotient, remainder, div_by_zero, e.q, e.r, e.dbz); end
  endtask

  task automatic test_reset_abort();
    int cyc; bit seen;
    issue(16'd200, 16'd9);
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    vectors++; if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin miscompares++;
      $display("FAIL abort_state got busy=%b done=%b q=%h r=%h z=%b want all 0", busy, done, quotient, remainder, div_by_zero); end
    wait_done(30, cyc, seen);
    vectors++; if (seen) begin miscompares++; $display("FAIL abort_no_done got done after %0d edges want none", cyc); end
  endtask

  task automatic test_random();
    int cyc; bit seen; exp_t e;
    logic [W-1:0] a, b;
    logic [2*W-1:0] recon;
    for (int n = 0; n < 1500; n++) begin
      a = W'($urandom);
      case ($urandom_range(0, 15))
        0:       b = '0;
        1, 2, 3: b = W'($urandom_range(1, 15));
        4:       b = W'($urandom_range(16'hFF00, 16'hFFFF));
        default: b = W'($urandom);
      endcase
      issue(a, b);
      wait_done(40, cyc, seen);
      e = sb.pop_front();
      vectors++; if (!seen || cyc != ((b == '0) ? 1 : 17) || {quotient, remainder, div_by_zero} !== e) begin miscompares++;
        $display("FAIL rand%0d %0d/%0d got q=%0d r=%0d z=%b edges=%0d want q=%0d r=%0d z=%b", n, a, b, quotient, remainder, div_by_zero, cyc, e.q, e.r, e.dbz); end
      if (b != '0) begin
        recon = quotient * b + {{W{1'b0}}, remainder};
        vectors++; if (recon !== {{W{1'b0}}, a} || remainder >= b) begin miscompares++;
          $display("FAIL rand%0d_invariant got q*d+r=%0d r=%0d want %0d with r<%0d", n, recon, remainder, a, b); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_ignore_in_run();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
